// File: rtl/cp_pkg.sv
// ---------------------------------------------------------------------------
// cp_pkg
// Shared definitions for the cyclic-prefix inserter:
//   - CP length select encodings (CP_SEL_I values)
//   - read-side FSM state encoding
//   - cp_len_f: CP length in samples for a given FFT size and select code
// ---------------------------------------------------------------------------
package cp_pkg;

   localparam logic [1:0] CP_QUARTER      = 2'b00;  // NFFT/4
   localparam logic [1:0] CP_EIGHTH       = 2'b01;  // NFFT/8
   localparam logic [1:0] CP_SIXTEENTH    = 2'b10;  // NFFT/16
   localparam logic [1:0] CP_THIRTYSECOND = 2'b11;  // NFFT/32

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CP   = 2'b01,
      ST_BODY = 2'b10
   } rd_state_e;

   // CP length = NFFT >> (2 + sel). Wide enough for LOG2N up to 11.
   function automatic logic [11:0] cp_len_f(input int unsigned log2n,
                                            input logic [1:0]   sel);
      logic [12:0] nfft;
      nfft = 13'd1 << log2n;
      return 12'(nfft >> (32'd2 + 32'(sel)));
   endfunction

endpackage

// File: rtl/cp_pingpong_buf.sv
// ---------------------------------------------------------------------------
// cp_pingpong_buf
// Two-bank sample store, each bank NFFT words of {real, imag}.
// Ports:
//   clk_i                 rising-edge clock
//   we_i, wr_bank_i,
//   wr_addr_i, wr_data_i  synchronous write port
//   rd_bank_i, rd_addr_i  asynchronous read address
//   rd_data_o             read data (combinational from address)
// Storage is intentionally not reset.
// ---------------------------------------------------------------------------
module cp_pingpong_buf
   import cp_pkg::*;
#(
   parameter int DW    = 16,
   parameter int LOG2N = 6
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic                wr_bank_i,
   input  logic [LOG2N-1:0]    wr_addr_i,
   input  logic [2*DW-1:0]     wr_data_i,
   input  logic                rd_bank_i,
   input  logic [LOG2N-1:0]    rd_addr_i,
   output logic [2*DW-1:0]     rd_data_o
);

   localparam int DEPTH = 2 * (1 << LOG2N);

   logic [2*DW-1:0] mem_q [DEPTH];

   // Write port: bank bit is the address MSB.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[{rd_bank_i, rd_addr_i}];

endmodule

// File: rtl/cp_insert_pp.sv
// ---------------------------------------------------------------------------
// cp_insert_pp
// Cyclic-prefix inserter with a two-bank ping-pong buffer. A full symbol of
// NFFT samples is collected into one bank, then emitted as its last cp_len
// samples followed by all NFFT samples while the other bank fills.
// Ports:
//   CLK_I               clock
//   RST_I               synchronous active-low reset
//   DAT_I_r/DAT_I_i     input sample, STB_I valid, ACK_O accept
//   CP_SEL_I            CP length select, latched at the first sample of a symbol
//   DAT_O_r/DAT_O_i     output sample, STB_O valid, ACK_I accept
//   SOF_O               marks the first CP sample of each extended symbol
// ---------------------------------------------------------------------------
module cp_insert_pp
   import cp_pkg::*;
#(
   parameter int DW    = 16,
   parameter int LOG2N = 6
) (
   input  logic          CLK_I,
   input  logic          RST_I,
   input  logic [DW-1:0] DAT_I_r,
   input  logic [DW-1:0] DAT_I_i,
   input  logic          STB_I,
   output logic          ACK_O,
   input  logic [1:0]    CP_SEL_I,
   output logic [DW-1:0] DAT_O_r,
   output logic [DW-1:0] DAT_O_i,
   output logic          STB_O,
   input  logic          ACK_I,
   output logic          SOF_O
);

   localparam int AW = LOG2N;
   localparam int CW = LOG2N - 1;
   localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

   // Write side state
   logic [AW-1:0] wr_cnt_q,  wr_cnt_d;
   logic          wr_bank_q, wr_bank_d;
   logic [CW-1:0] cp_len_q [2];
   logic [CW-1:0] cp_len_d [2];
   logic [1:0]    full_q,    full_d;

   // Read side state
   rd_state_e     state_q,   state_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          rd_bank_q, rd_bank_d;

   logic          ack_s;
   logic          wr_en_s;
   logic          wr_last_s;
   logic [1:0]    full_set_s;
   logic [1:0]    full_clr_s;
   logic          stb_s;
   logic          xfer_s;
   logic          other_full_s;
   logic [CW-1:0] cp_len_new_s;
   logic [AW-1:0] rd_start_s;
   logic [AW-1:0] other_start_s;
   logic [2*DW-1:0] rd_data_s;

   assign cp_len_new_s = CW'(cp_len_f(LOG2N, CP_SEL_I));

   assign ack_s     = RST_I & ~full_q[wr_bank_q];
   assign wr_en_s   = STB_I & ack_s;
   assign wr_last_s = wr_en_s & (wr_cnt_q == LAST_ADDR);

   assign stb_s  = RST_I & (state_q != ST_IDLE);
   assign xfer_s = stb_s & ACK_I;

   // NFFT - cp_len at AW bits: NFFT is 0 modulo 2**AW.
   assign rd_start_s    = {AW{1'b0}} - {1'b0, cp_len_q[rd_bank_q]};
   assign other_start_s = {AW{1'b0}} - {1'b0, cp_len_q[~rd_bank_q]};

   // The other bank counts as ready if it completes on this same edge, so a
   // simultaneous fill/drain hands over without a bubble.
   assign other_full_s = full_q[~rd_bank_q] | full_set_s[~rd_bank_q];

   // Write-side next state: counter, bank toggle, CP latch, full set.
   always_comb begin
      wr_cnt_d   = wr_cnt_q;
      wr_bank_d  = wr_bank_q;
      cp_len_d   = cp_len_q;
      full_set_s = 2'b00;
      if (wr_en_s) begin
         wr_cnt_d = wr_cnt_q + AW'(1);
         if (wr_cnt_q == {AW{1'b0}}) begin
            cp_len_d[wr_bank_q] = cp_len_new_s;
         end else begin
            cp_len_d[wr_bank_q] = cp_len_q[wr_bank_q];
         end
         if (wr_last_s) begin
            full_set_s[wr_bank_q] = 1'b1;
            wr_bank_d             = ~wr_bank_q;
         end else begin
            wr_bank_d = wr_bank_q;
         end
      end else begin
         wr_cnt_d = wr_cnt_q;
      end
   end

   // Read FSM next state: IDLE -> CP -> BODY -> (CP | IDLE).
   always_comb begin
      state_d    = state_q;
      rd_addr_d  = rd_addr_q;
      rd_bank_d  = rd_bank_q;
      full_clr_s = 2'b00;
      case (state_q)
         ST_IDLE: begin
            if (full_q[rd_bank_q]) begin
               state_d   = ST_CP;
               rd_addr_d = rd_start_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CP: begin
            if (xfer_s) begin
               if (rd_addr_q == LAST_ADDR) begin
                  state_d   = ST_BODY;
                  rd_addr_d = {AW{1'b0}};
               end else begin
                  rd_addr_d = rd_addr_q + AW'(1);
               end
            end else begin
               state_d = ST_CP;
            end
         end
         ST_BODY: begin
            if (xfer_s) begin
               if (rd_addr_q == LAST_ADDR) begin
                  full_clr_s[rd_bank_q] = 1'b1;
                  rd_bank_d             = ~rd_bank_q;
                  if (other_full_s) begin
                     state_d   = ST_CP;
                     rd_addr_d = other_start_s;
                  end else begin
                     state_d   = ST_IDLE;
                     rd_addr_d = {AW{1'b0}};
                  end
               end else begin
                  rd_addr_d = rd_addr_q + AW'(1);
               end
            end else begin
               state_d = ST_BODY;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            rd_addr_d = {AW{1'b0}};
         end
      endcase
   end

   // A bank is never set and cleared on the same edge: the read side only
   // frees the bank it is draining, which the write side cannot be filling.
   assign full_d = (full_q | full_set_s) & ~full_clr_s;

   // State registers with synchronous active-low reset.
   always_ff @(posedge CLK_I) begin
      if (!RST_I) begin
         wr_cnt_q    <= {AW{1'b0}};
         wr_bank_q   <= 1'b0;
         cp_len_q[0] <= {CW{1'b0}};
         cp_len_q[1] <= {CW{1'b0}};
         full_q      <= 2'b00;
         state_q     <= ST_IDLE;
         rd_addr_q   <= {AW{1'b0}};
         rd_bank_q   <= 1'b0;
      end else begin
         wr_cnt_q    <= wr_cnt_d;
         wr_bank_q   <= wr_bank_d;
         cp_len_q[0] <= cp_len_d[0];
         cp_len_q[1] <= cp_len_d[1];
         full_q      <= full_d;
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         rd_bank_q   <= rd_bank_d;
      end
   end

   cp_pingpong_buf #(
      .DW    (DW),
      .LOG2N (LOG2N)
   ) u_buf (
      .clk_i     (CLK_I),
      .we_i      (wr_en_s),
      .wr_bank_i (wr_bank_q),
      .wr_addr_i (wr_cnt_q),
      .wr_data_i ({DAT_I_r, DAT_I_i}),
      .rd_bank_i (rd_bank_q),
      .rd_addr_i (rd_addr_q),
      .rd_data_o (rd_data_s)
   );

   assign ACK_O   = ack_s;
   assign STB_O   = stb_s;
   assign SOF_O   = stb_s & (state_q == ST_CP) & (rd_addr_q == rd_start_s);
   assign DAT_O_r = stb_s ? rd_data_s[2*DW-1:DW] : {DW{1'b0}};
   assign DAT_O_i = stb_s ? rd_data_s[DW-1:0]    : {DW{1'b0}};

endmodule
